// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg: shared state type, default sizes and stats width for mult_arbiter
package mult_arb_pkg;
  typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;
  localparam int WIDTH_DEF = 4;
  localparam int NREQ_DEF = 2;
  localparam int STAT_W = 16;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr with wrap
module rr_arbiter import mult_arb_pkg::*; #(
  parameter int NREQ = NREQ_DEF,
  localparam int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] idx
);
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NREQ]) begin
        gnt = NREQ'(1) << ((int'(ptr) + k) % NREQ);
        idx = ID_W'((int'(ptr) + k) % NREQ);
      end
    end
  end
endmodule

// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin shared multiplier; MULT_ARB_STATS_EN adds stat_ops/stat_busy counters
module mult_arbiter import mult_arb_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREQ = NREQ_DEF,
  localparam int ID_W = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [2*WIDTH-1:0]    rsp_product,
  output logic [ID_W-1:0]       rsp_id
`ifdef MULT_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0]     stat_ops,
  output logic [STAT_W-1:0]     stat_busy
`endif
);
  state_t state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic [ID_W-1:0] g_q, ptr, idx;
  logic [NREQ-1:0] gnt;
  logic accept;
  rr_arbiter #(.NREQ(NREQ)) u_rr (.req(req_valid), .ptr(ptr), .gnt(gnt), .idx(idx));
  // rst_n gates the grant so req_ready stays low while reset is held
  assign accept = state == IDLE && |req_valid;
  assign req_ready = (state == IDLE && rst_n) ? gnt : '0;
  assign rsp_valid = state == RESP;
  always_comb begin
    state_nxt = state == IDLE ? (accept ? MUL : IDLE) :
                state == MUL  ? RESP :
                (rsp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_q <= '0;
      b_q <= '0;
      g_q <= '0;
      ptr <= '0;
      rsp_product <= '0;
      rsp_id <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_q <= req_a[idx*WIDTH +: WIDTH];
        b_q <= req_b[idx*WIDTH +: WIDTH];
        g_q <= idx;
        ptr <= idx == ID_W'(NREQ - 1) ? '0 : idx + 1'b1;
      end
      if (state == MUL) begin
        rsp_product <= (2*WIDTH)'(a_q) * (2*WIDTH)'(b_q);
        rsp_id <= g_q;
      end
    end
  end
`ifdef MULT_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops <= '0;
      stat_busy <= '0;
    end else begin
      if (rsp_valid && rsp_ready && stat_ops != '1) stat_ops <= stat_ops + 1'b1;
      if (state != IDLE && stat_busy != '1) stat_busy <= stat_busy + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: directed and random checks of mult_arbiter against a cycle-timestamp reference model
module tb_mult_arbiter;
  localparam int W = 4;
  localparam int N = 2;
  localparam int IW = $clog2(N);
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req_valid, req_ready;
  logic [N*W-1:0] req_a, req_b;
  logic rsp_valid, rsp_ready;
  logic [2*W-1:0] rsp_product;
  logic [IW-1:0] rsp_id;
`ifdef MULT_ARB_STATS_EN
  logic [15:0] stat_ops, stat_busy;
`endif
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int ptr = 0;
  int t_acc = 0;
  int n_hs = 0;
  int n_busy = 0;
  int g;
  bit free = 1'b1;
  bit mon_en = 1'b0;
  bit ev;
  logic [N-1:0] er;
  logic [N-1:0] last_rdy = '0;
  int exp_p[$];
  int exp_id[$];
  int hs_ids[$];
  int hs_cyc[$];

  mult_arbiter #(.WIDTH(W), .NREQ(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_product(rsp_product), .rsp_id(rsp_id)
`ifdef MULT_ARB_STATS_EN
    , .stat_ops(stat_ops), .stat_busy(stat_busy)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    ptr = 0;
    free = 1'b1;
    exp_p.delete();
    exp_id.delete();
    n_hs = 0;
    n_busy = 0;
  endtask

  // Reference: a grant is the first valid requester from ptr upward when free;
  // its response is due two cycles after the grant cycle and held until taken.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      er = '0;
      g = -1;
      if (free)
        for (int k = N - 1; k >= 0; k--) if (req_valid[(ptr + k) % N]) g = (ptr + k) % N;
      if (g >= 0) er[g] = 1'b1;
      chk("req_ready", req_ready, er);
      ev = !free && cyc >= t_acc + 2;
      chk("rsp_valid", rsp_valid, ev);
      if (!free) n_busy++;
      if (ev) begin
        chk("rsp_product", rsp_product, exp_p[0]);
        chk("rsp_id", rsp_id, exp_id[0]);
        if (rsp_ready) begin
          hs_ids.push_back(int'(rsp_id));
          hs_cyc.push_back(cyc);
          void'(exp_p.pop_front());
          void'(exp_id.pop_front());
          n_hs++;
          free = 1'b1;
        end
      end
      if (g >= 0) begin
        exp_p.push_back(int'(req_a[g*W +: W]) * int'(req_b[g*W +: W]));
        exp_id.push_back(g);
        ptr = (g + 1) % N;
        free = 1'b0;
        t_acc = cyc;
      end
      last_rdy = req_ready;
    end
  end

  task automatic wait_idle();
    int t = 0;
    while ((!free || rsp_valid) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("idle_timeout", free, 1);
  endtask

  task automatic op(int i, int a, int b, int ep);
    int t;
    @(posedge clk); #1;
    req_valid = '0;
    req_valid[i] = 1'b1;
    req_a[i*W +: W] = W'(a);
    req_b[i*W +: W] = W'(b);
    rsp_ready = 1'b1;
    t = 0;
    @(negedge clk);
    while (!req_ready[i] && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk("op_grant", req_ready[i], 1);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    t = 0;
    @(negedge clk);
    while (!rsp_valid && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk("op_valid", rsp_valid, 1);
    chk("op_product", rsp_product, ep);
    chk("op_id", rsp_id, i);
    wait_idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      req_valid = N'($urandom);
      req_a = (N*W)'($urandom);
      req_b = (N*W)'($urandom);
      rsp_ready = 1'($urandom);
      @(negedge clk);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_product", rsp_product, 0);
      chk("rst_rsp_id", rsp_id, 0);
    end
    @(posedge clk); #1;
    req_valid = '1;
    req_a = {4'd7, 4'd2};
    req_b = {4'd6, 4'd3};
    rsp_ready = 1'b1;
    model_reset();
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("first_grant", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle();

    op(0, 3, 5, 15);
    op(0, 0, 9, 0);

    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 2'b10;
    req_a[W +: W] = 4'd5;
    req_b[W +: W] = 4'd11;
    @(negedge clk);
    chk("bp_grant", req_ready, 2'b10);
    @(posedge clk); #1;
    req_valid = 2'b01;
    req_a[0 +: W] = 4'd2;
    req_b[0 +: W] = 4'd7;
    @(negedge clk);
    @(negedge clk);
    repeat (5) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_product", rsp_product, 55);
      chk("bp_id", rsp_id, 1);
      chk("bp_ready", req_ready, 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_done", rsp_valid, 1);
    @(negedge clk);
    chk("bp_next_grant", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle();

    op(1, 15, 15, 'hE1);

    hs_ids.delete();
    hs_cyc.delete();
    @(posedge clk); #1;
    req_valid = '1;
    req_a = {4'd9, 4'd4};
    req_b = {4'd13, 4'd6};
    rsp_ready = 1'b1;
    repeat (27) @(negedge clk);
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle();
    chk("fair_count", hs_ids.size() >= 8, 1);
    for (int k = 0; k < 8 && k < hs_ids.size(); k++) begin
      chk("fair_id", hs_ids[k], k % 2);
      if (k > 0) chk("fair_gap", hs_cyc[k] - hs_cyc[k-1], 3);
    end

    repeat (1500) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || last_rdy[i]) begin
          req_valid[i] = ($urandom % 3) != 0;
          req_a[i*W +: W] = W'($urandom);
          req_b[i*W +: W] = W'($urandom);
        end else if ($urandom % 10 == 0) req_valid[i] = 1'b0;
      end
      rsp_ready = ($urandom % 4) != 0;
    end
    @(posedge clk); #1;
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle();

    @(posedge clk); #1;
    req_valid = 2'b10;
    req_a[W +: W] = 4'd12;
    req_b[W +: W] = 4'd10;
    @(negedge clk);
    chk("mr_grant", req_ready, 2'b10);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mr_rsp_valid", rsp_valid, 0);
    chk("mr_rsp_product", rsp_product, 0);
    chk("mr_rsp_id", rsp_id, 0);
    chk("mr_req_ready", req_ready, 0);
    model_reset();
    @(posedge clk); #1;
    req_valid = '1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mr_grant0", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle();
    repeat (2) @(negedge clk);
`ifdef MULT_ARB_STATS_EN
    chk("stat_ops", stat_ops, n_hs);
    chk("stat_busy", stat_busy, n_busy);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
